axis_pgroup_tx: RTL and testbench
=================================

AXIS_PGROUP_TX -- requirements
Module: axis_pgroup_tx

Interface
REQ-001 SHALL have parameters, one per line:
- IP_AMT, 1, image processor count.
- IP_ADDR_W, $clog2(IP_AMT), processor index width.
- AXIS_TID_W, 2, tid width.
- AXIS_TDEST_W, (IP_ADDR_W>1)?IP_ADDR_W:1, tdest width.
- AXIS_TDATA_W, 256, pixel-group width.
- AXIS_TKEEP_W, AXIS_TDATA_W/8, tkeep width.
- AXIS_TSTRB_W, AXIS_TDATA_W/8, tstrb width.
- TID_VALUE, 0, constant tid.
- FRAME_ROW_PNUM, 240, pixel rows per frame.
- FRAME_COL_PGNUM, 10, pixel groups per row.
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- clk, in, 1, single clock, all logic on its rising edge.
- rst, in, 1, synchronous active-high reset.
- enable_i, in, 1, permits start of a new frame.
- pgroup_i, in, AXIS_TDATA_W, source pixel group.
- pgroup_valid_i, in, 1, source valid.
- pgroup_ready_o, out, 1, source ready.
- m_tid_o, out, AXIS_TID_W, stream ID.
- m_tdest_o, out, AXIS_TDEST_W, target processor.
- m_tdata_o, out, AXIS_TDATA_W, stream data.
- m_tkeep_o, out, AXIS_TKEEP_W, byte keep.
- m_tstrb_o, out, AXIS_TSTRB_W, byte strobe.
- m_tlast_o, out, 1, last beat of frame.
- m_tvalid_o, out, 1, master valid.
- m_tready_i, in, 1, slave ready.
- frame_done_o, out, 1, one-cycle pulse per completed frame.
REQ-003 SHALL use clk as the only clock and rst as a synchronous, active-high reset.

Function
REQ-004 SHALL implement FSM states IDLE, STREAM, FLUSH.
REQ-005 State transitions:
- IDLE->STREAM when enable_i=1.
- STREAM->FLUSH on acceptance of the frame's final input beat.
- FLUSH->IDLE on the cycle the tlast beat handshakes (m_tvalid_o & m_tready_i).
REQ-006 Input handshake = pgroup_valid_i & pgroup_ready_o. pgroup_ready_o SHALL be 1 only in STREAM with the output buffer not full; it is 0 in IDLE and FLUSH.
REQ-007 SHALL contain a 2-entry output skid buffer. pgroup_ready_o SHALL be a registered signal, equal to "fewer than 2 entries" after the current cycle's updates.
REQ-008 Latency: a beat accepted into an empty buffer in cycle N SHALL appear on m_* in cycle N+1.
REQ-009 All m_* outputs SHALL be driven from registers.
REQ-010 While m_tvalid_o=1 and m_tready_i=0, all m_* outputs SHALL hold stable.
REQ-011 Beat ordering SHALL be preserved; no beat is dropped or duplicated.
REQ-012 SHALL keep column counter col (0..FRAME_COL_PGNUM-1) and row counter row (0..FRAME_ROW_PNUM-1), both advanced per accepted input beat:
- col wraps to 0 and row increments at FRAME_COL_PGNUM-1.
- Both clear to 0 at end of frame.
REQ-013 m_tlast_o SHALL be 1 only on the beat accepted at row=FRAME_ROW_PNUM-1, col=FRAME_COL_PGNUM-1, giving exactly FRAME_ROW_PNUM*FRAME_COL_PGNUM beats per frame.
REQ-014 m_tkeep_o and m_tstrb_o SHALL be all ones; m_tid_o SHALL equal TID_VALUE.
REQ-015 Destination register dest:
- Drives m_tdest_o and is constant within a frame.
- Increments by 1 on the FLUSH->IDLE transition.
- Wraps from IP_AMT-1 to 0; with IP_AMT=1 it stays 0.
REQ-016 frame_done_o SHALL pulse high for exactly the cycle of the FLUSH->IDLE transition.
REQ-017 enable_i SHALL be sampled only in IDLE; deasserting it mid-frame SHALL NOT truncate the frame.
REQ-018 Simultaneous input accept and output pop in one cycle SHALL leave the occupancy unchanged.

Reset
REQ-019 In any cycle with rst=1, the next state SHALL be:
- FSM in IDLE; col, row and dest at 0; buffer empty.
- pgroup_ready_o=0, m_tvalid_o=0, m_tlast_o=0, frame_done_o=0.
- m_tdata_o=0, m_tdest_o=0.
REQ-020 A reset mid-frame SHALL discard buffered beats with no tlast emitted. The next frame SHALL start at row=0, col=0, dest=0.

Verification (FRAME_ROW_PNUM=2, FRAME_COL_PGNUM=3, IP_AMT=2)
REQ-021 Smoke test: enable_i=1, data 1..6 with valid and tready held high -> six beats with data 1..6, one per cycle after 1-cycle latency; tlast only on 6; tdest=0; frame_done_o pulses on the cycle beat 6 handshakes.
REQ-022 Back-to-back frames: two frames streamed -> the second frame carries tdest=1; a third frame carries tdest=0 (wrap).
REQ-023 Backpressure: m_tready_i=0 for 5 cycles mid-frame -> pgroup_ready_o falls after 2 buffered beats, outputs stay stable, and no beat is lost or reordered after release.
REQ-024 Random valid/ready toggling over 10 frames -> scoreboard shows data in order, exactly 6 beats per frame, tlast every 6th beat.
REQ-025 Reset mid-frame: rst asserted after beat 3 -> m_tvalid_o=0 the next cycle, no tlast emitted; the next frame restarts at beat 1 with tdest=0.
REQ-026 Enable gating: enable_i=0 in IDLE -> pgroup_ready_o stays 0 indefinitely; enable_i dropped after beat 2 -> the frame still completes all 6 beats.

Source files
------------

// File: rtl/axis_pgroup_tx.sv
// Pixel-group to AXI4-Stream transmitter. Frames are FRAME_ROW_PNUM x FRAME_COL_PGNUM
// beats, sent round-robin to IP_AMT processors through a 2-entry registered skid buffer.
module axis_pgroup_tx #(
  parameter int IP_AMT          = 1,
  parameter int IP_ADDR_W       = $clog2(IP_AMT),
  parameter int AXIS_TID_W      = 2,
  parameter int AXIS_TDEST_W    = (IP_ADDR_W > 1) ? IP_ADDR_W : 1,
  parameter int AXIS_TDATA_W    = 256,
  parameter int AXIS_TKEEP_W    = AXIS_TDATA_W / 8,
  parameter int AXIS_TSTRB_W    = AXIS_TDATA_W / 8,
  parameter int TID_VALUE       = 0,
  parameter int FRAME_ROW_PNUM  = 240,
  parameter int FRAME_COL_PGNUM = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable_i,
  input  logic [AXIS_TDATA_W-1:0] pgroup_i,
  input  logic                    pgroup_valid_i,
  output logic                    pgroup_ready_o,
  output logic [AXIS_TID_W-1:0]   m_tid_o,
  output logic [AXIS_TDEST_W-1:0] m_tdest_o,
  output logic [AXIS_TDATA_W-1:0] m_tdata_o,
  output logic [AXIS_TKEEP_W-1:0] m_tkeep_o,
  output logic [AXIS_TSTRB_W-1:0] m_tstrb_o,
  output logic                    m_tlast_o,
  output logic                    m_tvalid_o,
  input  logic                    m_tready_i,
  output logic                    frame_done_o
);
  localparam int COL_W = (FRAME_COL_PGNUM > 1) ? $clog2(FRAME_COL_PGNUM) : 1;
  localparam int ROW_W = (FRAME_ROW_PNUM > 1) ? $clog2(FRAME_ROW_PNUM) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_e;
  state_e state_q, state_d;

  logic [AXIS_TDATA_W-1:0] out_data_q, out_data_d, sk_data_q, sk_data_d;
  logic                    out_last_q, out_last_d, sk_last_q, sk_last_d;
  logic                    out_vld_q, out_vld_d, sk_vld_q, sk_vld_d;
  logic                    ready_q, ready_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic [AXIS_TDEST_W-1:0] dest_q, dest_d;
  logic                    push, pop, in_last, tlast_hs;

  assign push     = pgroup_valid_i & ready_q;
  assign pop      = out_vld_q & m_tready_i;
  assign in_last  = (row_q == ROW_W'(FRAME_ROW_PNUM - 1)) && (col_q == COL_W'(FRAME_COL_PGNUM - 1));
  assign tlast_hs = pop & out_last_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable_i) state_d = STREAM;
      STREAM:  if (push && in_last) state_d = FLUSH;
      FLUSH:   if (tlast_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ready is registered, so it must look at the buffer occupancy after this cycle's push/pop
  always_comb begin
    ready_d      = (state_d == STREAM) && !(out_vld_d && sk_vld_d);
    frame_done_o = (state_q == FLUSH) && tlast_hs;
  end

  // Output register is the buffer head; the skid entry only fills while the head is stalled.
  always_comb begin
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    sk_vld_d   = sk_vld_q;
    sk_data_d  = sk_data_q;
    sk_last_d  = sk_last_q;
    if (pop) begin
      if (sk_vld_q) begin
        out_data_d = sk_data_q;
        out_last_d = sk_last_q;
        sk_vld_d   = push;
        if (push) begin
          sk_data_d = pgroup_i;
          sk_last_d = in_last;
        end
      end else begin
        out_vld_d  = push;
        out_last_d = push & in_last;
        if (push) out_data_d = pgroup_i;
      end
    end else if (push) begin
      if (out_vld_q) begin
        sk_vld_d  = 1'b1;
        sk_data_d = pgroup_i;
        sk_last_d = in_last;
      end else begin
        out_vld_d  = 1'b1;
        out_data_d = pgroup_i;
        out_last_d = in_last;
      end
    end
  end

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    dest_d = dest_q;
    if (push) begin
      if (in_last) begin
        col_d = '0;
        row_d = '0;
      end else if (col_q == COL_W'(FRAME_COL_PGNUM - 1)) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
    if (frame_done_o)
      dest_d = (dest_q == AXIS_TDEST_W'(IP_AMT - 1)) ? '0 : dest_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      sk_vld_q   <= 1'b0;
      sk_data_q  <= '0;
      sk_last_q  <= 1'b0;
      ready_q    <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      dest_q     <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      sk_vld_q   <= sk_vld_d;
      sk_data_q  <= sk_data_d;
      sk_last_q  <= sk_last_d;
      ready_q    <= ready_d;
      col_q      <= col_d;
      row_q      <= row_d;
      dest_q     <= dest_d;
    end
  end

  assign pgroup_ready_o = ready_q;
  assign m_tvalid_o     = out_vld_q;
  assign m_tdata_o      = out_data_q;
  assign m_tlast_o      = out_last_q;
  assign m_tdest_o      = dest_q;
  assign m_tid_o        = AXIS_TID_W'(TID_VALUE);
  assign m_tkeep_o      = '1;
  assign m_tstrb_o      = '1;
endmodule

// File: tb/tb_axis_pgroup_tx.sv
// Scoreboard bench for axis_pgroup_tx: 2x3 frames, two processors.
module tb_axis_pgroup_tx;
  localparam int IP_AMT = 2;
  localparam int ROWS   = 2;
  localparam int COLS   = 3;
  localparam int FB     = ROWS * COLS;
  localparam int DW     = 256;
  localparam int TDW    = 1;
  localparam int TIDW   = 2;
  localparam int KW     = DW / 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           enable_i = 1'b0;
  logic [DW-1:0]  pgroup_i = '0;
  logic           pgroup_valid_i = 1'b0;
  logic           pgroup_ready_o;
  logic [TIDW-1:0] m_tid_o;
  logic [TDW-1:0] m_tdest_o;
  logic [DW-1:0]  m_tdata_o;
  logic [KW-1:0]  m_tkeep_o;
  logic [KW-1:0]  m_tstrb_o;
  logic           m_tlast_o;
  logic           m_tvalid_o;
  logic           m_tready_i = 1'b1;
  logic           frame_done_o;

  axis_pgroup_tx #(
    .IP_AMT(IP_AMT), .AXIS_TDATA_W(DW), .FRAME_ROW_PNUM(ROWS), .FRAME_COL_PGNUM(COLS)
  ) dut (
    .clk(clk), .rst(rst), .enable_i(enable_i),
    .pgroup_i(pgroup_i), .pgroup_valid_i(pgroup_valid_i), .pgroup_ready_o(pgroup_ready_o),
    .m_tid_o(m_tid_o), .m_tdest_o(m_tdest_o), .m_tdata_o(m_tdata_o),
    .m_tkeep_o(m_tkeep_o), .m_tstrb_o(m_tstrb_o), .m_tlast_o(m_tlast_o),
    .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i), .frame_done_o(frame_done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0]  data;
    logic           last;
    logic [TDW-1:0] dest;
    int             cyc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0, errors = 0;
  int   cyc = 0, data_next = 1, bif = 0, frame_idx = 0;
  int   frames_done = 0, fbeats = 0;
  bit   chk_lat = 1'b0;
  logic prev_vld = 1'b0, prev_rdy = 1'b0, prev_rst = 1'b1;
  logic [263:0] prev_bus = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [263:0] act, input logic [263:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected beat: data counts up, tlast on every FB-th beat, dest alternates per frame.
  task automatic accept();
    exp_t e;
    e.data = DW'(data_next);
    e.last = (bif == FB - 1);
    e.dest = TDW'(frame_idx % IP_AMT);
    e.cyc  = cyc;
    sbq.push_back(e);
    data_next++;
    bif++;
    if (e.last) begin
      bif = 0;
      frame_idx++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (pgroup_valid_i && pgroup_ready_o && !rst) accept();
    @(posedge clk);
    #1;
    pgroup_i = DW'(data_next);
  endtask

  task automatic send_beats(input int n, input int vprob, input bit rrand);
    int start = data_next;
    int guard = 0;
    pgroup_i = DW'(data_next);
    while (data_next - start < n && guard < 1000) begin
      pgroup_valid_i = ($urandom_range(99) < vprob);
      if (rrand) m_tready_i = 1'($urandom_range(1));
      step();
      guard++;
    end
    pgroup_valid_i = 1'b0;
    if (data_next - start < n) begin
      checks++; errors++;
      $display("FAIL send_timeout: sent %0d beats, required %0d", data_next - start, n);
    end
  endtask

  task automatic drain(input bit rrand);
    int guard = 0;
    while (sbq.size() != 0 && guard < 500) begin
      if (rrand) m_tready_i = 1'($urandom_range(1));
      step();
      guard++;
    end
    m_tready_i = 1'b1;
    repeat (2) step();
    chk("drain_empty", 32'(sbq.size()), 0);
  endtask

  always @(negedge clk) begin
    logic hs;
    exp_t e;
    hs = m_tvalid_o && m_tready_i;
    if (!rst) begin
      if (prev_vld && !prev_rdy && !prev_rst)
        chkw("hold_stable", 264'({m_tvalid_o, m_tlast_o, m_tdest_o, m_tdata_o}), prev_bus);
      if (hs) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got data %0h, required no beat", m_tdata_o);
        end else begin
          e = sbq.pop_front();
          chkw("tdata", 264'(m_tdata_o), 264'(e.data));
          chk("tlast", 32'(m_tlast_o), 32'(e.last));
          chk("tdest", 32'(m_tdest_o), 32'(e.dest));
          if (chk_lat) chk("latency", 32'(cyc - e.cyc), 1);
        end
        chk("tid", 32'(m_tid_o), 0);
        chk("tkeep_tstrb", {m_tkeep_o[15:0], m_tstrb_o[15:0]}, 32'hFFFF_FFFF);
        fbeats++;
        if (m_tlast_o) begin
          chk("frame_len", 32'(fbeats), FB);
          fbeats = 0;
        end
      end
      if (frame_done_o || (hs && m_tlast_o))
        chk("frame_done", 32'(frame_done_o), 32'(hs && m_tlast_o));
      if (frame_done_o) frames_done++;
    end else begin
      fbeats = 0;
    end
    prev_vld = m_tvalid_o;
    prev_rdy = m_tready_i;
    prev_rst = rst;
    prev_bus = 264'({m_tvalid_o, m_tlast_o, m_tdest_o, m_tdata_o});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int seen;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(pgroup_ready_o), 0);
    chk("rst_tvalid", 32'(m_tvalid_o), 0);
    chk("rst_tlast", 32'(m_tlast_o), 0);
    chk("rst_frame_done", 32'(frame_done_o), 0);
    chkw("rst_tdata", 264'(m_tdata_o), 0);
    chk("rst_tdest", 32'(m_tdest_o), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // smoke: one frame, continuous flow, 1-cycle latency
    chk_lat = 1'b1;
    enable_i = 1'b1;
    send_beats(FB, 100, 1'b0);
    drain(1'b0);
    chk_lat = 1'b0;

    // abort a frame after 3 beats with dest=1, then restart from scratch
    send_beats(3, 100, 1'b0);
    m_tready_i = 1'b0;
    step();
    rst = 1'b1;
    sbq.delete();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_tvalid", 32'(m_tvalid_o), 0);
    chk("abort_tlast", 32'(m_tlast_o), 0);
    chk("abort_ready", 32'(pgroup_ready_o), 0);
    chk("abort_tdest", 32'(m_tdest_o), 0);
    @(posedge clk); #1;
    frame_idx = 0; bif = 0; data_next = 1; frames_done = 0;
    m_tready_i = 1'b1;
    send_beats(FB, 100, 1'b0);
    drain(1'b0);

    // back-to-back frames: dest 1 then wraps to 0
    send_beats(2 * FB, 100, 1'b0);
    drain(1'b0);

    // backpressure: sink stalls 5 cycles, buffer fills and ready drops
    send_beats(2, 100, 1'b0);
    pgroup_valid_i = 1'b1;
    m_tready_i = 1'b0;
    repeat (5) step();
    chk("bp_ready_low", 32'(pgroup_ready_o), 0);
    chk("bp_tvalid", 32'(m_tvalid_o), 1);
    chk("bp_two_buffered", 32'(sbq.size()), 2);
    pgroup_valid_i = 1'b0;
    m_tready_i = 1'b1;
    send_beats(FB - bif, 100, 1'b0);
    drain(1'b0);

    // random valid/ready over 10 frames; enable dropped so FSM parks in IDLE afterwards
    repeat (10) send_beats(FB, 60, 1'b1);
    enable_i = 1'b0;
    drain(1'b1);

    // enable gating: nothing accepted while enable is low in IDLE
    seen = 0;
    pgroup_valid_i = 1'b1;
    repeat (20) begin
      step();
      if (pgroup_ready_o) seen++;
    end
    pgroup_valid_i = 1'b0;
    chk("gate_ready_low", 32'(seen), 0);
    enable_i = 1'b1;
    send_beats(2, 100, 1'b0);
    enable_i = 1'b0;
    send_beats(FB - 2, 100, 1'b0);
    drain(1'b0);

    // restart frame + 2 b2b + backpressure + 10 random + gated
    chk("frames_done", 32'(frames_done), 15);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
